// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, sync pulses, video window.
// Optional macro VGA_SYNC_PIPE_EN adds one clk of delay on hsync, vsync and video_on.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  function automatic logic in_win(input logic [9:0] pos, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  logic [3:0] div_cnt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       hsync_p0;
  logic       vsync_p0;
  logic       video_on_p0;

  always_comb begin
    x_nxt = pixel_x;
    y_nxt = pixel_y;
    if (p_tick) begin
      if (pixel_x == H_MAX) begin
        x_nxt = '0;
        y_nxt = (pixel_y == V_MAX) ? '0 : pixel_y + 10'd1;
      end else begin
        x_nxt = pixel_x + 10'd1;
      end
    end
  end

  // Stage p0: divider, counters, and syncs decoded from next-state counters so
  // they switch on the same edge as pixel_x/pixel_y.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      p_tick   <= 1'b0;
      pixel_x  <= '0;
      pixel_y  <= '0;
      hsync_p0 <= ~SYNC_ACT;
      vsync_p0 <= ~SYNC_ACT;
    end else begin
      div_cnt  <= (div_cnt == DIV_MAX) ? 4'd0 : div_cnt + 4'd1;
      p_tick   <= (div_cnt == DIV_MAX);
      pixel_x  <= x_nxt;
      pixel_y  <= y_nxt;
      hsync_p0 <= in_win(x_nxt, HS_START, HS_END) ? SYNC_ACT : ~SYNC_ACT;
      vsync_p0 <= in_win(y_nxt, VS_START, VS_END) ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign video_on_p0 = (pixel_x < H_VIS) && (pixel_y < V_VIS);
  assign frame_tick  = p_tick && (pixel_x == H_MAX) && (pixel_y == V_MAX);

`ifdef VGA_SYNC_PIPE_EN
  logic hsync_p1;
  logic vsync_p1;
  logic video_on_p1;

  // Stage p1: extra clk to line up with the synchronous font ROM output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_p1    <= ~SYNC_ACT;
      vsync_p1    <= ~SYNC_ACT;
      video_on_p1 <= 1'b0;
    end else begin
      hsync_p1    <= hsync_p0;
      vsync_p1    <= vsync_p0;
      video_on_p1 <= video_on_p0;
    end
  end

  assign hsync    = hsync_p1;
  assign vsync    = vsync_p1;
  assign video_on = video_on_p1;
`else
  assign hsync    = hsync_p0;
  assign vsync    = vsync_p0;
  assign video_on = video_on_p0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size timing at CLK_DIV=2 and a short-frame instance at CLK_DIV=1.
`timescale 1ns/1ps
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_EN
  localparam int PL = 1;
`else
  localparam int PL = 0;
`endif
  localparam int   HT      = 800;
  localparam int   N_CYC   = 12810;
  localparam logic VID_RST = (PL == 0);

  typedef struct packed {
    logic       p;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic       a_p_tick, a_video_on, a_hsync, a_vsync, a_frame_tick;
  logic [9:0] a_pixel_x, a_pixel_y;
  logic       b_p_tick, b_video_on, b_hsync, b_vsync, b_frame_tick;
  logic [9:0] b_pixel_x, b_pixel_y;

  vga_sync_gen dut_a (
    .clk(clk), .reset_n(rst_a_n), .p_tick(a_p_tick), .pixel_x(a_pixel_x),
    .pixel_y(a_pixel_y), .video_on(a_video_on), .hsync(a_hsync), .vsync(a_vsync),
    .frame_tick(a_frame_tick)
  );

  vga_sync_gen #(.CLK_DIV(1), .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .p_tick(b_p_tick), .pixel_x(b_pixel_x),
    .pixel_y(b_pixel_y), .video_on(b_video_on), .hsync(b_hsync), .vsync(b_vsync),
    .frame_tick(b_frame_tick)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference timing derived from the edge count k since reset release.
  function automatic exp_t model(input int k, input int d, input int vt,
                                 input int vdisp, input int vs_lo);
    exp_t e;
    int a, s, sx, sy;
    a    = (k < 1) ? 0 : (k - 1) / d;
    e.x  = 10'(a % HT);
    e.y  = 10'((a / HT) % vt);
    e.p  = (k >= 1) && (k % d == 0);
    e.ft = e.p && (a % HT == HT - 1) && ((a / HT) % vt == vt - 1);
    s    = (k - PL < 1) ? 0 : (k - PL - 1) / d;
    sx   = s % HT;
    sy   = (s / HT) % vt;
    e.hs  = !(sx >= 656 && sx <= 751);
    e.vs  = !(sy >= vs_lo && sy <= vs_lo + 1);
    e.vid = (sx < 640) && (sy < vdisp);
    return e;
  endfunction

  task automatic chk_reset_b(input string pfx);
    chk({pfx, "_ptick"}, b_p_tick, 0);
    chk({pfx, "_x"}, b_pixel_x, 0);
    chk({pfx, "_y"}, b_pixel_y, 0);
    chk({pfx, "_hsync"}, b_hsync, 1);
    chk({pfx, "_vsync"}, b_vsync, 1);
    chk({pfx, "_video"}, b_video_on, VID_RST);
    chk({pfx, "_ftick"}, b_frame_tick, 0);
  endtask

  initial begin
    exp_t ea_e, eb_e;
    int ea[7];
    int eb[7];
    int fx656 = -1, fhs = -1, fx640 = -1, fvid = -1;
    int ahs_cnt = 0, avid_cnt = 0, awn = 0, apx = 0;
    int awrap[2];
    int bhs_cnt = 0, bvs_cnt = 0, fy5 = -1, fbvs = -1, bwn = 0, bfn = 0;
    int bpx = 0, bpy = 0, bwrapchk = 0;
    int bwrap[2];
    int bft[2];
    for (int i = 0; i < 7; i++) begin
      ea[i] = 0;
      eb[i] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      awrap[i] = -1;
      bwrap[i] = -1;
      bft[i]   = -1;
    end

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("A_rst_ptick", a_p_tick, 0);
    chk("A_rst_x", a_pixel_x, 0);
    chk("A_rst_y", a_pixel_y, 0);
    chk("A_rst_hsync", a_hsync, 1);
    chk("A_rst_vsync", a_vsync, 1);
    chk("A_rst_video", a_video_on, VID_RST);
    chk("A_rst_ftick", a_frame_tick, 0);
    chk_reset_b("B_rst");

    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    for (int k = 1; k <= N_CYC; k++) begin
      @(negedge clk);
      if (k == 1) chk("A_ptick_k1", a_p_tick, 0);
      if (k == 2) chk("A_ptick_k2", a_p_tick, 1);
      if (k == 3) chk("A_ptick_k3", a_p_tick, 0);
      if (k == 3) chk("A_x_k3", a_pixel_x, 1);
      if (k == 4) chk("A_ptick_k4", a_p_tick, 1);

      ea_e = model(k, 2, 525, 480, 490);
      if (a_p_tick     !== ea_e.p)   ea[0]++;
      if (a_pixel_x    !== ea_e.x)   ea[1]++;
      if (a_pixel_y    !== ea_e.y)   ea[2]++;
      if (a_hsync      !== ea_e.hs)  ea[3]++;
      if (a_vsync      !== ea_e.vs)  ea[4]++;
      if (a_video_on   !== ea_e.vid) ea[5]++;
      if (a_frame_tick !== ea_e.ft)  ea[6]++;

      eb_e = model(k, 1, 8, 4, 5);
      if (b_p_tick     !== eb_e.p)   eb[0]++;
      if (b_pixel_x    !== eb_e.x)   eb[1]++;
      if (b_pixel_y    !== eb_e.y)   eb[2]++;
      if (b_hsync      !== eb_e.hs)  eb[3]++;
      if (b_vsync      !== eb_e.vs)  eb[4]++;
      if (b_video_on   !== eb_e.vid) eb[5]++;
      if (b_frame_tick !== eb_e.ft)  eb[6]++;

      if (a_pixel_x == 656 && fx656 < 0) fx656 = k;
      if (k >= 2 && a_hsync == 1'b0 && fhs < 0) fhs = k;
      if (a_pixel_x == 640 && fx640 < 0) fx640 = k;
      if (k >= 2 && a_video_on == 1'b0 && fvid < 0) fvid = k;
      if (k >= 1 + PL && k <= 1600 + PL) begin
        if (!a_hsync) ahs_cnt++;
        if (a_video_on) avid_cnt++;
      end
      if (a_pixel_x == 0 && apx == 799 && awn < 2) begin
        awrap[awn] = k;
        awn++;
      end
      apx = int'(a_pixel_x);

      if (k >= 1 + PL && k <= 800 + PL && !b_hsync) bhs_cnt++;
      if (k >= 1 + PL && k <= 6400 + PL && !b_vsync) bvs_cnt++;
      if (b_pixel_y == 5 && fy5 < 0) fy5 = k;
      if (k >= 2 && b_vsync == 1'b0 && fbvs < 0) fbvs = k;
      if (b_pixel_x == 0 && bpx == 799 && bwn < 2) begin
        bwrap[bwn] = k;
        bwn++;
      end
      if (b_frame_tick && bfn < 2) begin
        bft[bfn] = k;
        bfn++;
      end
      if (b_pixel_y == 0 && bpy == 7 && bwrapchk == 0) begin
        bwrapchk = 1;
        chk("B_wrap_prev_x", bpx, 799);
        chk("B_wrap_x", b_pixel_x, 0);
      end
      bpx = int'(b_pixel_x);
      bpy = int'(b_pixel_y);
    end

    chk("A_ptick_track", ea[0], 0);
    chk("A_x_track", ea[1], 0);
    chk("A_y_track", ea[2], 0);
    chk("A_hsync_track", ea[3], 0);
    chk("A_vsync_track", ea[4], 0);
    chk("A_video_track", ea[5], 0);
    chk("A_ftick_track", ea[6], 0);
    chk("B_ptick_track", eb[0], 0);
    chk("B_x_track", eb[1], 0);
    chk("B_y_track", eb[2], 0);
    chk("B_hsync_track", eb[3], 0);
    chk("B_vsync_track", eb[4], 0);
    chk("B_video_track", eb[5], 0);
    chk("B_ftick_track", eb[6], 0);

    chk("A_x656_k", fx656, 1313);
    chk("A_hsync_fall_k", fhs, 1313 + PL);
    chk("A_x640_k", fx640, 1281);
    chk("A_video_fall_k", fvid, 1281 + PL);
    chk("A_hsync_low_clks", ahs_cnt, 192);
    chk("A_video_high_clks", avid_cnt, 1280);
    chk("A_first_wrap_k", awrap[0], 1601);
    chk("A_line_period", awrap[1] - awrap[0], 1600);

    chk("B_hsync_low_clks", bhs_cnt, 96);
    chk("B_first_wrap_k", bwrap[0], 801);
    chk("B_line_period", bwrap[1] - bwrap[0], 800);
    chk("B_y5_k", fy5, 4001);
    chk("B_vsync_fall_k", fbvs, 4001 + PL);
    chk("B_vsync_low_clks", bvs_cnt, 1600);
    chk("B_first_ftick_k", bft[0], 6400);
    chk("B_frame_period", bft[1] - bft[0], 6400);
    chk("B_wrap_seen", bwrapchk, 1);

    // Mid-line asynchronous reset on the short-frame instance.
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    repeat (2701) @(negedge clk);
    chk("B_mid_x", b_pixel_x, 300);
    chk("B_mid_y", b_pixel_y, 3);
    #2 rst_b_n = 1'b0;
    #1 chk_reset_b("B_async");
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    chk("B_restart_ptick", b_p_tick, 1);
    chk("B_restart_x0", b_pixel_x, 0);
    @(negedge clk);
    chk("B_restart_x1", b_pixel_x, 1);
    chk("B_restart_y", b_pixel_y, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
